// File: rtl/memory_responder_pkg.sv
// -----------------------------------------------------------------------------
// memory_responder_pkg
//   Shared definitions for the memory responder: default geometry of the word
//   array and the responder FSM state encoding.
// -----------------------------------------------------------------------------
package memory_responder_pkg;

    // Default word-address width (array holds 2^MEM_ADDR_WIDTH words).
    localparam int MEM_ADDR_WIDTH = 12;
    // Default data word width.
    localparam int MEM_WIDE       = 16;

    // CLEAR: zero-fill sweep in progress, requests dropped.
    // IDLE : requests accepted.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

endpackage : memory_responder_pkg

// File: rtl/memory_responder_memory_array.sv
// -----------------------------------------------------------------------------
// memory_array
//   Plain synchronous single-port RAM with a registered, write-first read port.
//   Kept free of any responder-specific logic so it can be replaced by a
//   vendor macro with the same behaviour.
//
// Ports:
//   clk   - clock, all state on rising edge
//   srst  - synchronous active-high reset, clears only the output register
//   we    - write enable: mem[addr] <= din
//   re    - read enable: dout <= mem[addr] (or din when we is also high)
//   addr  - word address
//   din   - write data
//   dout  - registered read data, holds when re is low
// -----------------------------------------------------------------------------
module memory_array #(
    parameter int ADDR_WIDTH = 12,
    parameter int WIDE       = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDE-1:0]       din,
    output logic [WIDE-1:0]       dout
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDE-1:0] mem_q [0:DEPTH-1];
    logic [WIDE-1:0] dout_q;
    logic [WIDE-1:0] dout_d;

    // Array write port: no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

    // Write-first: a simultaneous read returns the data being written.
    always_comb begin
        dout_d = dout_q;
        if (re) begin
            dout_d = we ? din : mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule : memory_array

// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
//   Memory-side responder for the 16-bit processor memory port. Answers the
//   enable/read/write request stream with registered read data, zero-fills its
//   word array after reset (optional) and drops requests during that sweep.
//
// Ports:
//   clk          - system clock
//   reset        - synchronous active-high reset
//   mem_enable   - request qualifier
//   read_enable  - read request
//   write_enable - write request
//   address      - word address
//   data_in      - write data
//   data_out     - registered read data (holds except on read / write-first)
//   ready        - high when requests are accepted
//   drop_error   - one-cycle pulse after a request was dropped during the sweep
// -----------------------------------------------------------------------------
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
    parameter int WIDE           = MEM_WIDE,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_enable,
    input  logic                  read_enable,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WIDE-1:0]       data_in,
    output logic [WIDE-1:0]       data_out,
    output logic                  ready,
    output logic                  drop_error
);

    localparam state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    // One bit wider than the address: the carry marks the end of the sweep.
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  drop_q, drop_d;

    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WIDE-1:0]       ram_din;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drop_d   = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = address;
        ram_din  = data_in;

        case (state_q)
            CLEAR: begin
                // Sweep owns the RAM port; the request path is ignored.
                ram_we   = 1'b1;
                ram_addr = cnt_q[ADDR_WIDTH-1:0];
                ram_din  = '0;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_d[ADDR_WIDTH]) begin
                    state_d = IDLE;
                end
                drop_d = mem_enable && (read_enable || write_enable);
            end
            IDLE: begin
                ram_we = mem_enable && write_enable;
                ram_re = mem_enable && read_enable;
            end
        endcase

        // Nothing touches the array while reset is held.
        if (reset) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDE       (WIDE)
    ) u_memory_array (
        .clk  (clk),
        .srst (reset),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (data_out)
    );

    assign ready      = (state_q == IDLE);
    assign drop_error = drop_q;

endmodule : memory_responder
